// File: rtl/dvi_encoder_top.sv
// Two-stage DVI 1.0 TMDS encoder: 24-bit RGB plus sync/de in, three 10-bit symbols plus the clock pattern out.
// Optional macro DVI_CTL_EN adds ctl[3:0] to carry C0/C1 on the green and red channels.
module dvi_encoder_top #(
   parameter logic [9:0] CLK_PATTERN = 10'b0000011111
) (
   input  logic       pclk,
   input  logic       rstin,
   input  logic [7:0] blue_din,
   input  logic [7:0] green_din,
   input  logic [7:0] red_din,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       de,
`ifdef DVI_CTL_EN
   input  logic [3:0] ctl,
`endif
   output logic [9:0] tmds_blue,
   output logic [9:0] tmds_green,
   output logic [9:0] tmds_red,
   output logic [9:0] tmds_clk
);

   localparam logic [9:0] TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] TOKEN_11 = 10'b1010101011;

   function automatic logic [3:0] countOnes(input logic [7:0] d);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
      return n;
   endfunction

   function automatic logic [8:0] minimiseTransitions(input logic [7:0] d);
      logic [3:0] n1;
      logic       useXnor;
      logic [8:0] qm;
      n1      = countOnes(d);
      useXnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
      qm      = '0;
      qm[0]   = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8]   = ~useXnor;
      return qm;
   endfunction

   // Returns {next disparity, symbol}; disparity math is done one bit wider to avoid wrap.
   function automatic logic [14:0] tmdsEncode(input logic [8:0] qm, input logic signed [4:0] cnt);
      logic [3:0]        n1;
      logic signed [5:0] diff;
      logic signed [5:0] cntWide;
      logic signed [5:0] cntNext;
      logic [9:0]        sym;
      n1      = countOnes(qm[7:0]);
      diff    = $signed({1'b0, n1, 1'b0}) - 6'sd8;
      cntWide = {cnt[4], cnt};
      if (cnt == 5'sd0 || diff == 6'sd0) begin
         sym     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cntNext = qm[8] ? cntWide + diff : cntWide - diff;
      end else if ((cnt > 5'sd0 && diff > 6'sd0) || (cnt < 5'sd0 && diff < 6'sd0)) begin
         sym     = {1'b1, qm[8], ~qm[7:0]};
         cntNext = cntWide + (qm[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
         sym     = {1'b0, qm[8], qm[7:0]};
         cntNext = cntWide - (qm[8] ? 6'sd0 : 6'sd2) + diff;
      end
      return {cntNext[4:0], sym};
   endfunction

   function automatic logic [9:0] controlToken(input logic [1:0] c);
      case (c)
         2'b01:   return TOKEN_01;
         2'b10:   return TOKEN_10;
         2'b11:   return TOKEN_11;
         default: return TOKEN_00;
      endcase
   endfunction

   logic [7:0]        pixel [3];
   logic [1:0]        ctlIn [3];
   logic [8:0]        qm_d [3];
   logic [8:0]        qm_q [3];
   logic [1:0]        ctl_q [3];
   logic              de_q;
   logic [9:0]        sym_d [3];
   logic [9:0]        sym_q [3];
   logic signed [4:0] cnt_d [3];
   logic signed [4:0] cnt_q [3];

   assign pixel[0] = blue_din;
   assign pixel[1] = green_din;
   assign pixel[2] = red_din;
   assign ctlIn[0] = {vsync, hsync};
`ifdef DVI_CTL_EN
   assign ctlIn[1] = ctl[1:0];
   assign ctlIn[2] = ctl[3:2];
`else
   assign ctlIn[1] = 2'b00;
   assign ctlIn[2] = 2'b00;
`endif

   always_comb begin
      for (int ch = 0; ch < 3; ch++) qm_d[ch] = minimiseTransitions(pixel[ch]);
   end

   always_ff @(posedge pclk) begin
      if (rstin) begin
         de_q <= 1'b0;
         for (int ch = 0; ch < 3; ch++) begin
            qm_q[ch]  <= '0;
            ctl_q[ch] <= 2'b00;
         end
      end else begin
         de_q <= de;
         for (int ch = 0; ch < 3; ch++) begin
            qm_q[ch]  <= qm_d[ch];
            ctl_q[ch] <= ctlIn[ch];
         end
      end
   end

   // Control periods clear each channel's running disparity so data restarts balanced.
   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         sym_d[ch] = controlToken(ctl_q[ch]);
         cnt_d[ch] = 5'sd0;
         if (de_q) {cnt_d[ch], sym_d[ch]} = tmdsEncode(qm_q[ch], cnt_q[ch]);
      end
   end

   always_ff @(posedge pclk) begin
      if (rstin) begin
         for (int ch = 0; ch < 3; ch++) begin
            sym_q[ch] <= TOKEN_00;
            cnt_q[ch] <= 5'sd0;
         end
      end else begin
         for (int ch = 0; ch < 3; ch++) begin
            sym_q[ch] <= sym_d[ch];
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   assign tmds_blue  = sym_q[0];
   assign tmds_green = sym_q[1];
   assign tmds_red   = sym_q[2];
   assign tmds_clk   = CLK_PATTERN;

endmodule

// File: tb/tb_dvi_encoder_top.sv
// Randomised bench for dvi_encoder_top against a behavioural TMDS model with a 2-cycle expectation queue.
// Directed sequences add literal-value checks for tokens, zero-balance, XNOR path and disparity clearing.
module tb_dvi_encoder_top;

   logic       pclk = 1'b0;
   logic       rstin;
   logic [7:0] blue_din, green_din, red_din;
   logic       hsync, vsync, de;
`ifdef DVI_CTL_EN
   logic [3:0] ctlBus;
`endif
   logic [9:0] tmds_blue, tmds_green, tmds_red, tmds_clk;

   int vectorCount = 0;
   int missCount   = 0;

   typedef struct packed {
      logic [2:0][9:0] sym;
      logic [2:0][7:0] pix;
      logic            isData;
   } expEntry_t;

   expEntry_t expQ[$];
   int        modelCnt [3];

   always #5 pclk = ~pclk;

   dvi_encoder_top dut (
      .pclk      (pclk),
      .rstin     (rstin),
      .blue_din  (blue_din),
      .green_din (green_din),
      .red_din   (red_din),
      .hsync     (hsync),
      .vsync     (vsync),
      .de        (de),
`ifdef DVI_CTL_EN
      .ctl       (ctlBus),
`endif
      .tmds_blue (tmds_blue),
      .tmds_green(tmds_green),
      .tmds_red  (tmds_red),
      .tmds_clk  (tmds_clk)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [9:0] tokenOf(input logic [1:0] c);
      logic [9:0] tok;
      case (c)
         2'd0:    tok = 10'h354;
         2'd1:    tok = 10'h0AB;
         2'd2:    tok = 10'h154;
         default: tok = 10'h2AB;
      endcase
      return tok;
   endfunction

   // q_m bit i is the parity of D[0..i], inverted on odd positions when the XNOR chain is chosen.
   function automatic logic [8:0] modelQm(input logic [7:0] d);
      int         ones;
      bit         useXnor;
      logic [8:0] qm;
      logic [7:0] mask;
      ones    = $countones(d);
      useXnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      for (int i = 0; i < 8; i++) begin
         mask  = 8'hFF >> (7 - i);
         qm[i] = (^(d & mask)) ^ (useXnor && (i % 2 == 1));
      end
      qm[8] = !useXnor;
      return qm;
   endfunction

   function automatic logic [7:0] decodeSym(input logic [9:0] s);
      logic [7:0] q, d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   // Drives one pixel, advances one clock, then checks the symbols for the pixel sent one cycle earlier.
   task automatic applyStimulus(input logic rst, input logic deIn, input logic hs, input logic vs,
                                input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
      expEntry_t  e, got;
      logic [7:0] pix [3];
      logic [1:0] ctlSel [3];
      logic [8:0] qm;
      logic [9:0] obs [3];
      string      chName [3];
      int         n1, n0, q8;
      chName = '{"blue", "green", "red"};
      rstin = rst; de = deIn; hsync = hs; vsync = vs;
      blue_din = b; green_din = g; red_din = r;
      pix[0] = b; pix[1] = g; pix[2] = r;
      ctlSel[0] = {vs, hs};
`ifdef DVI_CTL_EN
      ctlSel[1] = ctlBus[1:0];
      ctlSel[2] = ctlBus[3:2];
`else
      ctlSel[1] = 2'b00;
      ctlSel[2] = 2'b00;
`endif
      e = '0;
      if (!rst) begin
         e.isData = deIn;
         for (int ch = 0; ch < 3; ch++) begin
            e.pix[ch] = pix[ch];
            if (!deIn) begin
               e.sym[ch]    = tokenOf(ctlSel[ch]);
               modelCnt[ch] = 0;
            end else begin
               qm = modelQm(pix[ch]);
               n1 = $countones(qm[7:0]);
               n0 = 8 - n1;
               q8 = qm[8] ? 1 : 0;
               if (modelCnt[ch] == 0 || n1 == n0) begin
                  e.sym[ch] = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                  modelCnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
               end else if ((modelCnt[ch] > 0 && n1 > n0) || (modelCnt[ch] < 0 && n0 > n1)) begin
                  e.sym[ch] = {1'b1, qm[8], ~qm[7:0]};
                  modelCnt[ch] += 2 * q8 + (n0 - n1);
               end else begin
                  e.sym[ch] = {1'b0, qm[8], qm[7:0]};
                  modelCnt[ch] += -2 * (1 - q8) + (n1 - n0);
               end
            end
         end
      end
      @(posedge pclk);
      #1;
      obs[0] = tmds_blue; obs[1] = tmds_green; obs[2] = tmds_red;
      checkOutput("clkPattern", tmds_clk, 10'h01F);
      if (rst) begin
         expQ.delete();
         modelCnt = '{0, 0, 0};
         e.sym = {3{10'h354}};
         expQ.push_back(e);
         for (int ch = 0; ch < 3; ch++)
            checkOutput($sformatf("reset_%s", chName[ch]), obs[ch], 10'h354);
      end else begin
         expQ.push_back(e);
         got = expQ.pop_front();
         for (int ch = 0; ch < 3; ch++) begin
            checkOutput($sformatf("sym_%s", chName[ch]), obs[ch], got.sym[ch]);
            if (got.isData)
               checkOutput($sformatf("decode_%s", chName[ch]), decodeSym(obs[ch]), got.pix[ch]);
         end
      end
   endtask

   task automatic sendControl(input logic hs, input logic vs);
      applyStimulus(1'b0, 1'b0, hs, vs, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic sendData(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, b, g, r);
   endtask

   task automatic checkAll(input string tag, input logic [9:0] expected);
      checkOutput({tag, "_blue"}, tmds_blue, expected);
      checkOutput({tag, "_green"}, tmds_green, expected);
      checkOutput({tag, "_red"}, tmds_red, expected);
   endtask

   logic [9:0] tokTable [4];

   initial begin
      tokTable = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
      rstin = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
      blue_din = '0; green_din = '0; red_din = '0;
`ifdef DVI_CTL_EN
      ctlBus = 4'h0;
`endif
      modelCnt = '{0, 0, 0};

      // Reset held for three cycles while the inputs churn.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom));

      // Control token sweep on the blue channel.
      for (int k = 0; k < 4; k++) begin
         sendControl(k[0], k[1]);
         if (k > 0) begin
            checkOutput("token_blue", tmds_blue, tokTable[k-1]);
            checkOutput("token_green", tmds_green, 10'h354);
         end
      end
      sendControl(1'b0, 1'b0);
      checkOutput("token_blue", tmds_blue, tokTable[3]);
      checkOutput("token_red", tmds_red, 10'h354);

      // Zero data after control: 0x100, 0x3FF, 0x100.
      sendData(8'h00, 8'h00, 8'h00);
      sendData(8'h00, 8'h00, 8'h00);
      checkAll("zero0", 10'h100);
      sendData(8'h00, 8'h00, 8'h00);
      checkAll("zero1", 10'h3FF);
      sendControl(1'b0, 1'b0);
      checkAll("zero2", 10'h100);

      // XNOR path from a balanced start.
      sendControl(1'b0, 1'b0);
      sendData(8'hFF, 8'h00, 8'h00);
      sendControl(1'b0, 1'b0);
      checkOutput("xnor_blue", tmds_blue, 10'h200);
      checkOutput("xnor_green", tmds_green, 10'h100);

      // A single control cycle must clear the running disparity.
      sendData(8'h00, 8'h00, 8'h00);
      sendData(8'h00, 8'h00, 8'h00);
      sendData(8'h00, 8'h00, 8'h00);
      sendControl(1'b1, 1'b0);
      checkAll("clear_pre", 10'h100);
      sendData(8'h00, 8'h00, 8'h00);
      checkOutput("clear_gap", tmds_blue, 10'h0AB);
      sendControl(1'b0, 1'b0);
      checkAll("clear_post", 10'h100);

      // Random lines of 320 active plus 24 blanking pixels, with a reset mid-stream.
      for (int line = 0; line < 3; line++) begin
         for (int p = 0; p < 344; p++) begin
`ifdef DVI_CTL_EN
            ctlBus = 4'($urandom);
`endif
            applyStimulus(1'b0, p < 320, 1'($urandom), 1'($urandom),
                          8'($urandom), 8'($urandom), 8'($urandom));
         end
         if (line == 1) begin
            for (int i = 0; i < 3; i++)
               applyStimulus(1'b1, 1'b1, 1'($urandom), 1'($urandom),
                             8'($urandom), 8'($urandom), 8'($urandom));
         end
      end
      sendControl(1'b0, 1'b0);
      sendControl(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
